if_id_buffer: RTL and testbench
===============================

# if_id_buffer

Fetch-to-decode instruction buffer for the five-stage pipeline. It sits directly downstream of the fetch stage and captures each `{instruction, PC_Next}` pair that fetch produces into a small circular FIFO. It holds those entries while decode stalls and discards them on a taken branch. When it has nothing valid to present, it shows decode a NOP. Its `fetch_ready_out` output is the stall input that freezes the PC in fetch.

## Interface
Parameters:
- `DEPTH`, 2: number of entries; legal values are 2 or 4 only.
- `NOP_INSTR`, 16'h0800: encoding driven on `instr_out` when the buffer is empty or flushed.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `fetch_valid_in`  in  1  fetch presents a valid instruction this cycle (instruction memory not stalled, no branch redirect).
- `fetch_instr_in`  in  16  instruction word from instruction memory.
- `fetch_pc_next_in`  in  16  PC+2 (or held PC) from fetch.
- `fetch_ready_out`  out  1  buffer can accept a push; fetch holds its PC when low.
- `decode_stall_in`  in  1  decode hazard; head entry must not be consumed.
- `flush_in`  in  1  taken branch resolved in MEM/WB; discard all entries.
- `valid_out`  out  1  `instr_out`/`pc_next_out` hold a real instruction.
- `instr_out`  out  16  head instruction, or `NOP_INSTR`.
- `pc_next_out`  out  16  head PC_Next, or 16'h0000 when not valid.
- `count_out`  out  3  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH × 32-bit entries `{pc_next, instr}`.
  - Write pointer, read pointer, occupancy counter.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally.
- push = `fetch_valid_in & fetch_ready_out & ~flush_in`.
- pop = `valid_out & ~decode_stall_in & ~flush_in`.
- `fetch_ready_out` = (count < DEPTH).
  - It depends only on registered state; there is no combinational path from `decode_stall_in`.
  - When full, a push is refused even if a pop occurs in the same cycle.
- Occupancy update:
  - push only: count +1.
  - pop only: count −1.
  - push and pop together: count unchanged.
  - Both pointers advance independently.
- Flush has priority over everything else:
  - count, write pointer and read pointer all return to 0 at the next edge.
  - Any same-cycle push is dropped.
  - Outputs show NOP / invalid from the following cycle.
- Head output: if count > 0, drive the entry at the read pointer with `valid_out` = 1. Otherwise drive `NOP_INSTR`, 16'h0000 and `valid_out` = 0.
- Entry contents are not cleared on pop or flush; only the pointers and count change.

## Timing
- Reset state (asynchronous, while `rst` = 0):
  - count = 0, pointers = 0.
  - `valid_out` = 0, `instr_out` = `NOP_INSTR`, `pc_next_out` = 16'h0000.
  - `fetch_ready_out` = 1, `count_out` = 0.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
- Push-to-decode latency is 1 cycle: an entry pushed at edge N is visible at the outputs after edge N.
- With `decode_stall_in` held high, head outputs are stable for every cycle of the stall.
- Full (count = DEPTH): `fetch_ready_out` = 0 in that cycle. It returns to 1 in the cycle after the first pop.
- Empty with `decode_stall_in` = 1: there is no pop, and NOP is still presented.
- When `flush_in` and `decode_stall_in` are both high, the flush wins.

## Configuration
- `IF_ID_BYPASS_EN` defined:
  - When count = 0 and `fetch_valid_in` = 1, the incoming instruction and PC are driven combinationally on the outputs in the same cycle, with `valid_out` = 1.
  - If it is also popped that cycle (`decode_stall_in` = 0, `flush_in` = 0), it is not written to storage and count stays 0.
  - If decode stalls, it is pushed normally.
  - Zero-cycle latency.
- `IF_ID_BYPASS_EN` undefined: strict 1-cycle latency as described under Timing; no combinational path from fetch inputs to the outputs.

## Test plan
- Reset: hold `rst` = 0 for 3 cycles with random inputs → `valid_out` = 0, `instr_out` = 16'h0800, `count_out` = 0, `fetch_ready_out` = 1 throughout.
- Streaming: push 16'h4001/16'h0002, 16'h4002/16'h0004, 16'h4003/16'h0006 on consecutive cycles with no stall → outputs appear in order one cycle later; count never exceeds 1; no bypass.
- Fill and stall (DEPTH = 2): stall decode, push 3 instructions → count reaches 2; `fetch_ready_out` = 0; the third push is refused; `instr_out` is held at the first instruction; after releasing the stall the two entries drain in order.
- Flush: with count = 2, assert `flush_in` together with a push of 16'hBEEF → next cycle count = 0, `valid_out` = 0, `instr_out` = 16'h0800; 16'hBEEF is never presented.
- Pointer wrap (DEPTH = 4): 10 push/pop pairs with random stalls → order preserved across wrap; count stays within 0..4.
- Bypass (`IF_ID_BYPASS_EN`): with the buffer empty, push 16'h1234 → `instr_out` = 16'h1234 in the same cycle; count stays 0 when not stalled, becomes 1 when stalled.

Source files
------------

// File: rtl/if_id_buffer.sv
// if_id_buffer: fetch-to-decode circular instruction FIFO with NOP fill.
// Define IF_ID_BYPASS_EN to forward fetch straight to decode when empty.
module if_id_buffer #(
   parameter int unsigned DEPTH     = 2,
   parameter logic [15:0] NOP_INSTR = 16'h0800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_valid_in,
   input  logic [15:0] fetch_instr_in,
   input  logic [15:0] fetch_pc_next_in,
   output logic        fetch_ready_out,
   input  logic        decode_stall_in,
   input  logic        flush_in,
   output logic        valid_out,
   output logic [15:0] instr_out,
   output logic [15:0] pc_next_out,
   output logic [2:0]  count_out
);

   localparam int unsigned PW = (DEPTH > 2) ? 2 : 1;

   typedef struct packed {
      logic [15:0] pc_next;
      logic [15:0] instr;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [2:0]    count;

   logic empty;
   logic full;
   logic bypass;
   logic push;
   logic pop;
   logic wr_en;
   logic rd_en;

   assign empty           = (count == 3'd0);
   assign full            = (count >= 3'(DEPTH));
   assign fetch_ready_out = ~full;
   assign count_out       = count;

`ifdef IF_ID_BYPASS_EN
   // Forwarding is gated by reset so decode sees NOP while held in reset.
   assign bypass = rst & empty & fetch_valid_in;
`else
   assign bypass = 1'b0;
`endif

   assign push  = fetch_valid_in & ~full & ~flush_in;
   assign pop   = valid_out & ~decode_stall_in & ~flush_in;
   assign wr_en = push & ~(bypass & pop);
   assign rd_en = pop & ~bypass;

   always_comb begin
      valid_out   = 1'b0;
      instr_out   = NOP_INSTR;
      pc_next_out = 16'h0000;
      if (!empty) begin
         valid_out   = 1'b1;
         instr_out   = mem[rd_ptr].instr;
         pc_next_out = mem[rd_ptr].pc_next;
      end else if (bypass) begin
         valid_out   = 1'b1;
         instr_out   = fetch_instr_in;
         pc_next_out = fetch_pc_next_in;
      end
   end

   // Storage is never cleared; count alone decides what is live.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= '{pc_next: fetch_pc_next_in,
                          instr:   fetch_instr_in};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= 3'd0;
      end else if (flush_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= 3'd0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         if (rd_en) rd_ptr <= rd_ptr + PW'(1);
         unique case ({wr_en, rd_en})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: vector table plus queue-model random checks on
// two buffer instances (DEPTH 2 and DEPTH 4) sharing one input stream.
module tb_if_id_buffer;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        fv;
   logic [15:0] fi;
   logic [15:0] fp;
   logic        stall;
   logic        flush;

   logic        rdy2, vo2, rdy4, vo4;
   logic [15:0] io2, po2, io4, po4;
   logic [2:0]  co2, co4;

   if_id_buffer #(.DEPTH(2)) dut2 (
      .clk(clk), .rst(rst),
      .fetch_valid_in(fv), .fetch_instr_in(fi),
      .fetch_pc_next_in(fp), .fetch_ready_out(rdy2),
      .decode_stall_in(stall), .flush_in(flush),
      .valid_out(vo2), .instr_out(io2),
      .pc_next_out(po2), .count_out(co2)
   );

   if_id_buffer #(.DEPTH(4)) dut4 (
      .clk(clk), .rst(rst),
      .fetch_valid_in(fv), .fetch_instr_in(fi),
      .fetch_pc_next_in(fp), .fetch_ready_out(rdy4),
      .decode_stall_in(stall), .flush_in(flush),
      .valid_out(vo4), .instr_out(io4),
      .pc_next_out(po4), .count_out(co4)
   );

   int errors = 0;
   int checks = 0;

   function void chk(string n, logic [31:0] a, logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endfunction

   // Reference model: one queue of {pc_next, instr} per instance.
   logic [31:0] mq [2][$];
   int          md [2];

   task automatic model_expect(input int k, output logic v,
                               output logic [15:0] i,
                               output logic [15:0] p,
                               output logic r, output logic [2:0] c);
      logic [31:0] h;
      r = (mq[k].size() < md[k]);
      c = 3'(mq[k].size());
      v = 1'b0;
      i = 16'h0800;
      p = 16'h0000;
      if (mq[k].size() > 0) begin
         h = mq[k][0];
         v = 1'b1;
         i = h[15:0];
         p = h[31:16];
      end
`ifdef IF_ID_BYPASS_EN
      else if (rst && fv) begin
         v = 1'b1;
         i = fi;
         p = fp;
      end
`endif
   endtask

   task automatic model_edge(input int k);
      logic v, r, take, dopop, dopush;
      logic [15:0] i, p;
      logic [2:0] c;
      if (!rst || flush) begin
         mq[k].delete();
      end else begin
         model_expect(k, v, i, p, r, c);
         dopop  = v && !stall;
         dopush = fv && r;
         take   = dopop && (mq[k].size() == 0);
         if (!take) begin
            if (dopop) void'(mq[k].pop_front());
            if (dopush) mq[k].push_back({fp, fi});
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic v, r;
      logic [15:0] i, p;
      logic [2:0] c;
      for (int k = 0; k < 2; k++) begin
         model_expect(k, v, i, p, r, c);
         chk($sformatf("%s d%0d valid", tag, md[k]), k ? vo4 : vo2, v);
         chk($sformatf("%s d%0d instr", tag, md[k]), k ? io4 : io2, i);
         chk($sformatf("%s d%0d pc", tag, md[k]), k ? po4 : po2, p);
         chk($sformatf("%s d%0d ready", tag, md[k]), k ? rdy4 : rdy2, r);
         chk($sformatf("%s d%0d count", tag, md[k]), k ? co4 : co2, c);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] i,
                        input logic [15:0] p, input logic s,
                        input logic f);
      fv = v; fi = i; fp = p; stall = s; flush = f;
   endtask

   task automatic at_neg(input string tag);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic at_pos();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
   endtask

   typedef struct {
      logic        v;
      logic [15:0] i;
      logic [15:0] p;
      logic        s;
      logic        f;
      logic        ev;
      logic [15:0] ei;
      logic [15:0] ep;
      logic [2:0]  ec;
      logic        er;
   } vec_t;

   vec_t tv [$];

   function void vec(logic v, logic [15:0] i, logic [15:0] p,
                     logic s, logic f, logic ev, logic [15:0] ei,
                     logic [15:0] ep, logic [2:0] ec, logic er);
      vec_t t;
      t.v = v;   t.i = i;   t.p = p;   t.s = s;   t.f = f;
      t.ev = ev; t.ei = ei; t.ep = ep; t.ec = ec; t.er = er;
      tv.push_back(t);
   endfunction

   initial begin
      md[0] = 2;
      md[1] = 4;
      rst = 1'b0;
      drive(0, 0, 0, 0, 0);

      // Reset held for three cycles with random inputs.
      for (int n = 0; n < 3; n++) begin
         drive(1'($urandom), 16'($urandom), 16'($urandom),
               1'($urandom), 1'($urandom));
         @(negedge clk);
         chk("rst valid", {vo2, vo4}, 2'b00);
         chk("rst instr2", io2, 16'h0800);
         chk("rst instr4", io4, 16'h0800);
         chk("rst pc2", po2, 16'h0000);
         chk("rst count", {co2, co4}, 6'd0);
         chk("rst ready", {rdy2, rdy4}, 2'b11);
         at_pos();
      end
      rst = 1'b1;

      // DEPTH=2 vectors: streaming, fill/stall, flush.
      vec(1, 16'h4001, 16'h0002, 0, 0, 0, 16'h0800, 16'h0000, 0, 1);
      vec(1, 16'h4002, 16'h0004, 0, 0, 1, 16'h4001, 16'h0002, 1, 1);
      vec(1, 16'h4003, 16'h0006, 0, 0, 1, 16'h4002, 16'h0004, 1, 1);
      vec(0, 16'h0000, 16'h0000, 0, 0, 1, 16'h4003, 16'h0006, 1, 1);
      vec(0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0800, 16'h0000, 0, 1);
      vec(1, 16'h5001, 16'h0010, 1, 0, 0, 16'h0800, 16'h0000, 0, 1);
      vec(1, 16'h5002, 16'h0012, 1, 0, 1, 16'h5001, 16'h0010, 1, 1);
      vec(1, 16'h5003, 16'h0014, 1, 0, 1, 16'h5001, 16'h0010, 2, 0);
      vec(1, 16'h5003, 16'h0014, 0, 0, 1, 16'h5001, 16'h0010, 2, 0);
      vec(1, 16'h5003, 16'h0014, 0, 0, 1, 16'h5002, 16'h0012, 1, 1);
      vec(0, 16'h0000, 16'h0000, 0, 0, 1, 16'h5003, 16'h0014, 1, 1);
      vec(0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0800, 16'h0000, 0, 1);
      vec(1, 16'h6001, 16'h0020, 1, 0, 0, 16'h0800, 16'h0000, 0, 1);
      vec(1, 16'h6002, 16'h0022, 1, 0, 1, 16'h6001, 16'h0020, 1, 1);
      vec(1, 16'hBEEF, 16'h0024, 1, 1, 1, 16'h6001, 16'h0020, 2, 0);
      vec(0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0800, 16'h0000, 0, 1);
      vec(1, 16'hBEEF, 16'h0026, 0, 1, 0, 16'h0800, 16'h0000, 0, 1);
      vec(0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0800, 16'h0000, 0, 1);

`ifndef IF_ID_BYPASS_EN
      foreach (tv[n]) begin
         drive(tv[n].v, tv[n].i, tv[n].p, tv[n].s, tv[n].f);
         at_neg($sformatf("vec%0d", n));
         chk($sformatf("tbl%0d valid", n), vo2, tv[n].ev);
         chk($sformatf("tbl%0d instr", n), io2, tv[n].ei);
         chk($sformatf("tbl%0d pc", n), po2, tv[n].ep);
         chk($sformatf("tbl%0d count", n), co2, tv[n].ec);
         chk($sformatf("tbl%0d ready", n), rdy2, tv[n].er);
         at_pos();
      end
`endif

      // Asynchronous reset in the middle of a cycle.
      drive(1, 16'h7001, 16'h0030, 1, 0);
      at_neg("pre-arst");
      at_pos();
      drive(1, 16'h7002, 16'h0032, 1, 0);
      at_neg("pre-arst");
      at_pos();
      #2;
      rst = 1'b0;
      mq[0].delete();
      mq[1].delete();
      #1;
      chk("arst valid", {vo2, vo4}, 2'b00);
      chk("arst count2", co2, 3'd0);
      chk("arst count4", co4, 3'd0);
      chk("arst instr2", io2, 16'h0800);
      chk("arst ready", {rdy2, rdy4}, 2'b11);
      at_pos();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      at_neg("post-arst");
      at_pos();

      // Random traffic; stall-heavy first half forces full and wrap.
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 3) != 0, 16'($urandom),
               16'($urandom),
               (n < 200) ? ($urandom_range(0, 1) == 0)
                         : ($urandom_range(0, 4) == 0),
               $urandom_range(0, 24) == 0);
         at_neg("rnd");
         at_pos();
      end

`ifdef IF_ID_BYPASS_EN
      drive(0, 0, 0, 0, 1);
      at_neg("byp-flush");
      at_pos();
      drive(1, 16'h1234, 16'h0002, 0, 0);
      at_neg("byp-go");
      chk("byp instr", {io2, io4}, {16'h1234, 16'h1234});
      chk("byp valid", {vo2, vo4}, 2'b11);
      at_pos();
      drive(0, 0, 0, 0, 0);
      at_neg("byp-after");
      chk("byp count0", {co2, co4}, 6'd0);
      at_pos();
      drive(1, 16'h1234, 16'h0002, 1, 0);
      at_neg("byp-stall");
      chk("byp stall instr", io2, 16'h1234);
      at_pos();
      drive(0, 0, 0, 1, 0);
      at_neg("byp-held");
      chk("byp count1", {co2, co4}, {3'd1, 3'd1});
      at_pos();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
